// File: rtl/cp0_pkg.sv
// ============================================================================
// Module      : cp0_pkg
// Description : Shared register numbers, field positions, exception codes and
//               constants for the CP0 controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] C_REG_SR    = 5'd12;
  localparam logic [4:0] C_REG_CAUSE = 5'd13;
  localparam logic [4:0] C_REG_EPC   = 5'd14;
  localparam logic [4:0] C_REG_PRID  = 5'd15;

  // SR field positions
  localparam int C_SR_IE     = 0;
  localparam int C_SR_EXL    = 1;
  localparam int C_SR_IM_LO  = 10;
  localparam int C_SR_IM_HI  = 15;

  // Cause field positions
  localparam int C_CAUSE_EXC_LO = 2;
  localparam int C_CAUSE_EXC_HI = 6;
  localparam int C_CAUSE_IP_LO  = 10;
  localparam int C_CAUSE_IP_HI  = 15;
  localparam int C_CAUSE_BD     = 31;

  localparam logic [31:0] C_PRID_VALUE   = 32'h4342_5541;
  localparam logic [31:0] C_HANDLER_ADDR = 32'h0000_4180;

  // Exception codes
  localparam logic [4:0] C_EXC_INT     = 5'd0;
  localparam logic [4:0] C_EXC_ADEL    = 5'd4;
  localparam logic [4:0] C_EXC_ADES    = 5'd5;
  localparam logic [4:0] C_EXC_SYSCALL = 5'd8;
  localparam logic [4:0] C_EXC_RI      = 5'd10;
  localparam logic [4:0] C_EXC_OV      = 5'd12;

  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  typedef struct packed {
    logic       bd;
    logic [5:0] ip;
    logic [4:0] exccode;
  } cause_t;

  function automatic logic [31:0] pack_sr(input sr_t s);
    logic [31:0] v;
    v = 32'd0;
    v[C_SR_IM_HI:C_SR_IM_LO] = s.im;
    v[C_SR_EXL]              = s.exl;
    v[C_SR_IE]               = s.ie;
    return v;
  endfunction

  function automatic logic [31:0] pack_cause(input cause_t c);
    logic [31:0] v;
    v = 32'd0;
    v[C_CAUSE_BD]                    = c.bd;
    v[C_CAUSE_IP_HI:C_CAUSE_IP_LO]   = c.ip;
    v[C_CAUSE_EXC_HI:C_CAUSE_EXC_LO] = c.exccode;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_ctrl.sv
// ============================================================================
// Module      : cp0_ctrl
// Description : CP0 status/cause/EPC/PRId registers with interrupt and
//               exception request generation for the M stage.
//               Optional macro CP0_EPC_FWD_EN forwards an in-flight mtc0 EPC
//               value onto epc_out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_ctrl
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exccode_in,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic        req,
  output logic [31:0] epc_out
);

  sr_t         r_sr;
  cause_t      r_cause;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_wr_sr;
  logic        w_wr_epc;
  logic [31:0] w_epc_capture;

  assign w_int_req = r_sr.ie & ~r_sr.exl & (|(hw_int & r_sr.im));
  assign w_exc_req = ~r_sr.exl & (exccode_in != 5'd0);
  assign req       = w_int_req | w_exc_req;

  assign w_wr_sr  = we & ~req & (cp0_addr == C_REG_SR);
  assign w_wr_epc = we & ~req & (cp0_addr == C_REG_EPC);

  // A delay-slot instruction restarts at its branch; wraps modulo 2^32
  assign w_epc_capture = bd_in ? (vpc - 32'd4) : vpc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr    <= '0;
      r_cause <= '0;
      r_epc   <= 32'd0;
    end else begin
      r_cause.ip <= hw_int;
      if (req) begin
        r_sr.exl        <= 1'b1;
        r_cause.bd      <= bd_in;
        r_cause.exccode <= w_int_req ? C_EXC_INT : exccode_in;
        r_epc           <= w_epc_capture;
      end else begin
        if (w_wr_sr) begin
          r_sr.im  <= cp0_wdata[C_SR_IM_HI:C_SR_IM_LO];
          r_sr.exl <= cp0_wdata[C_SR_EXL];
          r_sr.ie  <= cp0_wdata[C_SR_IE];
        end
        if (w_wr_epc) begin
          r_epc <= cp0_wdata;
        end
        // eret takes priority over a same-cycle SR write of EXL
        if (eret) begin
          r_sr.exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      C_REG_SR:    cp0_rdata = pack_sr(r_sr);
      C_REG_CAUSE: cp0_rdata = pack_cause(r_cause);
      C_REG_EPC:   cp0_rdata = r_epc;
      C_REG_PRID:  cp0_rdata = C_PRID_VALUE;
      default:     cp0_rdata = 32'd0;
    endcase
  end

`ifdef CP0_EPC_FWD_EN
  assign epc_out = w_wr_epc ? cp0_wdata : r_epc;
`else
  assign epc_out = r_epc;
`endif

endmodule

`default_nettype wire
